// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / hazard unit: tracks in-flight register writers and resolves Decode sources.
// Optional stall counter enabled by FWD_HAZARD_SCOREBOARD_PERF_EN.
module fwd_hazard_scoreboard #(
    parameter int NSRC = 2,
    parameter int NFWD = 2,
    parameter int REGW = 5,
    localparam int SELW = $clog2(NFWD + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_d,
    input  logic [NSRC*REGW-1:0]   rs_d,
    input  logic [NSRC-1:0]        src_en_d,
    input  logic [REGW-1:0]        rd_d,
    input  logic                   regwrite_d,
    input  logic [SELW-1:0]        rdy_d,
    input  logic                   flush_e,
    input  logic                   stall_ext,
    output logic                   stall_d,
    output logic [NSRC*SELW-1:0]   fwd_sel_e
`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
    ,
    input  logic                   stall_cnt_clr,
    output logic [31:0]            stall_cnt
`endif
);

    // Entry p describes the producer p stages past EX; entry 0 is EX itself.
    logic            tag_v   [NFWD];
    logic [REGW-1:0] tag_rd  [NFWD];
    logic [SELW-1:0] tag_rdy [NFWD];

    logic [SELW-1:0]      rdy_norm;
    logic [NSRC*SELW-1:0] sel_d;
    logic [NSRC-1:0]      hazard;

    // Out-of-range ready stages are treated as the latest forwarding stage.
    always_comb begin
        rdy_norm = rdy_d;
        if (rdy_d == '0 || int'(rdy_d) > NFWD)
            rdy_norm = SELW'(NFWD);
    end

    always_comb begin : resolve
        logic            hit;
        logic [REGW-1:0] rs;
        sel_d  = '0;
        hazard = '0;
        hit    = 1'b0;
        rs     = '0;
        for (int s = 0; s < NSRC; s++) begin
            hit = 1'b0;
            rs  = rs_d[s*REGW +: REGW];
            if (src_en_d[s] && valid_d && rs != '0) begin
                for (int p = 0; p < NFWD; p++) begin
                    if (!hit && tag_v[p] && tag_rd[p] == rs) begin
                        hit = 1'b1;
                        if (int'(tag_rdy[p]) <= p + 1)
                            sel_d[s*SELW +: SELW] = SELW'(p + 1);
                        else
                            hazard[s] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_d = |hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NFWD; p++) begin
                tag_v[p]   <= 1'b0;
                tag_rd[p]  <= '0;
                tag_rdy[p] <= '0;
            end
        end else if (!stall_ext) begin
            for (int p = NFWD - 1; p > 0; p--) begin
                tag_v[p]   <= tag_v[p-1];
                tag_rd[p]  <= tag_rd[p-1];
                tag_rdy[p] <= tag_rdy[p-1];
            end
            if (flush_e || stall_d)
                tag_v[0] <= 1'b0;
            else
                tag_v[0] <= valid_d & regwrite_d & (rd_d != '0);
            tag_rd[0]  <= rd_d;
            tag_rdy[0] <= rdy_norm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fwd_sel_e <= '0;
        else if (!stall_ext) begin
            if (flush_e || stall_d)
                fwd_sel_e <= '0;
            else
                fwd_sel_e <= sel_d;
        end
    end

`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
    // Counts Decode stall cycles that are not masked by a global freeze; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall_cnt_clr)
            stall_cnt <= '0;
        else if (stall_d && !stall_ext && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with default parameters.
module tb_fwd_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       valid_d;
    logic [9:0] rs_d;
    logic [1:0] src_en_d;
    logic [4:0] rd_d;
    logic       regwrite_d;
    logic [1:0] rdy_d;
    logic       flush_e;
    logic       stall_ext;
    logic       stall_d;
    logic [3:0] fwd_sel_e;
`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
    logic        stall_cnt_clr;
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fwd_hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .valid_d    (valid_d),
        .rs_d       (rs_d),
        .src_en_d   (src_en_d),
        .rd_d       (rd_d),
        .regwrite_d (regwrite_d),
        .rdy_d      (rdy_d),
        .flush_e    (flush_e),
        .stall_ext  (stall_ext),
        .stall_d    (stall_d),
`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt),
`endif
        .fwd_sel_e  (fwd_sel_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && valid_d && regwrite_d)
            assert (rdy_d >= 2'd1 && rdy_d <= 2'd2) else begin
                errors++;
                $error("FAIL rdy_d_legal observed=%0d expected=1..2", rdy_d);
            end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] en, input logic [4:0] rd, input logic rw,
                         input logic [1:0] rdy);
        valid_d    = v;
        rs_d       = {r1, r0};
        src_en_d   = en;
        rd_d       = rd;
        regwrite_d = rw;
        rdy_d      = rdy;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        flush_e = 1'b0;
        stall_ext = 1'b0;
`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
        stall_cnt_clr = 1'b0;
`endif
        nop();
        #2;
        chk("reset_stall_d", 32'(stall_d), 32'd0);
        chk("reset_fwd_sel", 32'(fwd_sel_e), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1. ALU back-to-back
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 2'd1);
        #1 chk("s1_prod_stall", 32'(stall_d), 32'd0);
        tick();
        drive(1'b1, 5'd5, 5'd3, 2'b11, 5'd8, 1'b1, 2'd1);
        #1 chk("s1_cons_stall", 32'(stall_d), 32'd0);
        tick();
        chk("s1_fwd_sel", 32'(fwd_sel_e), 32'h1);
        drain();
        chk("s1_drain_sel", 32'(fwd_sel_e), 32'h0);

        // 2. Distance two on rs2
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 2'd1);
        tick();
        nop();
        tick();
        drive(1'b1, 5'd1, 5'd5, 2'b11, 5'd9, 1'b1, 2'd1);
        #1 chk("s2_stall", 32'(stall_d), 32'd0);
        tick();
        chk("s2_fwd_sel", 32'(fwd_sel_e), 32'h8);
        drain();

        // 3. Load-use
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd6, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd2, 5'd6, 2'b11, 5'd10, 1'b1, 2'd1);
        #1 chk("s3_stall_on", 32'(stall_d), 32'd1);
        tick();
        chk("s3_bubble_sel", 32'(fwd_sel_e), 32'h0);
        chk("s3_stall_off", 32'(stall_d), 32'd0);
        tick();
        chk("s3_fwd_sel", 32'(fwd_sel_e), 32'h8);
        drain();

        // 4a. Writer of x0 then reader of x0
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd11, 1'b1, 2'd1);
        #1 chk("s4a_stall", 32'(stall_d), 32'd0);
        tick();
        chk("s4a_fwd_sel", 32'(fwd_sel_e), 32'h0);
        drain();

        // 4b. Matching load producer but sources disabled
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd5, 5'd5, 2'b00, 5'd12, 1'b1, 2'd1);
        #1 chk("s4b_stall", 32'(stall_d), 32'd0);
        tick();
        chk("s4b_fwd_sel", 32'(fwd_sel_e), 32'h0);
        drain();

        // 5. Youngest wins: older load x7 at entry 1, younger ALU x7 at entry 0
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 2'd1);
        tick();
        drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd13, 1'b1, 2'd1);
        #1 chk("s5_stall", 32'(stall_d), 32'd0);
        tick();
        chk("s5_fwd_sel", 32'(fwd_sel_e), 32'h5);
        drain();

        // 6a. Freeze during load-use, with a non-zero select held in EX
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 2'd1);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 2'd2);
        tick();
        chk("s6a_pre_sel", 32'(fwd_sel_e), 32'h1);
        drive(1'b1, 5'd2, 5'd6, 2'b11, 5'd10, 1'b1, 2'd1);
        stall_ext = 1'b1;
        #1 chk("s6a_stall_on", 32'(stall_d), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s6a_frz_stall", 32'(stall_d), 32'd1);
            chk("s6a_frz_sel", 32'(fwd_sel_e), 32'h1);
        end
        stall_ext = 1'b0;
        #1 chk("s6a_rel_stall", 32'(stall_d), 32'd1);
        tick();
        chk("s6a_bubble_sel", 32'(fwd_sel_e), 32'h0);
        chk("s6a_stall_off", 32'(stall_d), 32'd0);
        tick();
        chk("s6a_fwd_sel", 32'(fwd_sel_e), 32'h8);
        drain();

        // 6b. Flushed producer is never forwarded
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 2'd1);
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd14, 1'b1, 2'd1);
        #1 chk("s6b_stall", 32'(stall_d), 32'd0);
        tick();
        chk("s6b_fwd_sel", 32'(fwd_sel_e), 32'h0);
        drain();

        // 6c. Reset mid-stall clears everything asynchronously
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 2'd1);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd2, 5'd6, 2'b11, 5'd10, 1'b1, 2'd1);
        #1 chk("s6c_stall_on", 32'(stall_d), 32'd1);
        chk("s6c_pre_sel", 32'(fwd_sel_e), 32'h1);
        #1 reset = 1'b1;
        #1 chk("s6c_rst_stall", 32'(stall_d), 32'd0);
        chk("s6c_rst_sel", 32'(fwd_sel_e), 32'h0);
        #1 reset = 1'b0;
        tick();
        chk("s6c_post_sel", 32'(fwd_sel_e), 32'h0);
        chk("s6c_post_stall", 32'(stall_d), 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
